ula_decode_stage: RTL and testbench

- Decode/operand-issue stage sitting directly upstream of the ALU.
- Accepts one 32-bit MIPS-subset instruction per cycle over a valid/ready handshake.
- Reads operands from an internal 32×32 register file and translates opcode/funct into the ALU's 4-bit control code.
- Registers control, operands and writeback metadata for the ALU's next clock edge; a pending-write scoreboard stalls issue on read-after-write hazards.

---
 rtl/ula_decode_stage_pkg.sv | 55 +++++
 rtl/ula_decode_stage_if.sv | 36 +++
 rtl/ula_decode_stage_reg_file.sv | 42 ++++
 rtl/ula_decode_stage.sv | 154 +++++++++++++++
 tb/tb_ula_decode_stage.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_decode_stage_pkg.sv
// Shared definitions for the decode stage and the ALU: control codes,
// opcode/funct values, instruction field positions and the decode record.
package ula_pkg;

  localparam int REG_COUNT = 32;
  localparam int XLEN      = 32;

  typedef logic [4:0] reg_idx_t;

  // ALU control codes, also consumed by the ALU itself
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_ctrl_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;

  // Everything the stage needs to know about one instruction
  typedef struct packed {
    logic      legal;
    alu_ctrl_e ctrl;
    logic      use_imm;     // B operand is sext(imm) instead of rt
    logic      reads_rt;    // rt participates in hazard detection
    logic      dest_write;
    logic      dest_is_rt;  // I-type destination is rt, R-type is rd
    logic      mem_read;
    logic      mem_write;
  } decode_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/ula_decode_stage_if.sv
// Instruction handshake, writeback port and ALU-facing issue bus.
interface ula_decode_stage_if;
  import ula_pkg::*;

  logic [XLEN-1:0] instr;
  logic            instrValid;
  logic            instrReady;
  logic            wbEnable;
  logic [4:0]      wbAddr;
  logic [XLEN-1:0] wbData;
  logic [3:0]      inputULA;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            issueValid;
  logic [4:0]      destReg;
  logic            destWrite;
  logic            memRead;
  logic            memWrite;
  logic [XLEN-1:0] storeData;
  logic            illegal;

  // Upstream / writeback side
  modport master (
    output instr, instrValid, wbEnable, wbAddr, wbData,
    input  instrReady, inputULA, a, b, issueValid, destReg, destWrite,
           memRead, memWrite, storeData, illegal
  );

  // Decode stage side
  modport slave (
    input  instr, instrValid, wbEnable, wbAddr, wbData,
    output instrReady, inputULA, a, b, issueValid, destReg, destWrite,
           memRead, memWrite, storeData, illegal
  );

endinterface

// File: rtl/ula_decode_stage_reg_file.sv
// 32x32 register file: two async read ports, one sync write port with
// same-cycle write bypass, register 0 reads as zero.
module reg_file
  import ula_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  reg_idx_t        waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  reg_idx_t        raddr_a_i,
  output logic [XLEN-1:0] rdata_a_o,
  input  reg_idx_t        raddr_b_i,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] regs_q [REG_COUNT];
  logic            wr_fire;

  // Writes to register 0 are dropped so it stays zero
  assign wr_fire = we_i && (waddr_i != '0);

  // Storage: async clear, single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (wr_fire) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports with bypass of the write being committed this cycle
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    rdata_b_o = regs_q[raddr_b_i];
    if (wr_fire && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (wr_fire && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
    if (raddr_a_i == '0) rdata_a_o = '0;
    if (raddr_b_i == '0) rdata_b_o = '0;
  end

endmodule

// File: rtl/ula_decode_stage.sv
// Decode / operand-issue stage in front of the ALU. Decodes the instruction,
// reads operands, stalls on RAW hazards via a pending-write scoreboard and
// registers everything the ALU needs for its next edge.
module ula_decode_stage
  import ula_pkg::*;
(
  input logic               clk,
  input logic               rst,
  ula_decode_stage_if.slave bus
);

  function automatic decode_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    decode_t d;
    d       = '0;
    d.legal = 1'b1;
    d.ctrl  = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        d.reads_rt   = 1'b1;
        d.dest_write = 1'b1;
        case (funct)
          FN_ADD:  d.ctrl = ALU_ADD;
          FN_SUB:  d.ctrl = ALU_SUB;
          FN_AND:  d.ctrl = ALU_AND;
          FN_OR:   d.ctrl = ALU_OR;
          FN_SLT:  d.ctrl = ALU_SLT;
          default: d.legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        d.use_imm = 1'b1; d.dest_write = 1'b1; d.dest_is_rt = 1'b1;
      end
      OP_SLTI: begin
        d.ctrl = ALU_SLT;
        d.use_imm = 1'b1; d.dest_write = 1'b1; d.dest_is_rt = 1'b1;
      end
      OP_LW: begin
        d.use_imm = 1'b1; d.dest_write = 1'b1; d.dest_is_rt = 1'b1;
        d.mem_read = 1'b1;
      end
      OP_SW: begin
        d.use_imm = 1'b1; d.reads_rt = 1'b1; d.mem_write = 1'b1;
      end
      OP_BEQ: begin
        d.ctrl = ALU_SUB; d.reads_rt = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    // An unsupported instruction must leave no side effects behind
    if (!d.legal) begin
      d.dest_write = 1'b0;
      d.mem_read   = 1'b0;
      d.mem_write  = 1'b0;
    end
    return d;
  endfunction

  logic [5:0]      opcode, funct;
  reg_idx_t        rs, rt, rd, dest;
  logic [15:0]     imm;
  decode_t         dec;
  logic [XLEN-1:0] rs_val, rt_val;
  logic            hazard, accept, issue;

  logic [REG_COUNT-1:0] pending_q, pending_d, wb_clear, pending_eff;

  alu_ctrl_e       ctrl_q;
  logic [XLEN-1:0] a_q, b_q, store_q;
  reg_idx_t        dest_q;
  logic            dest_write_q, mem_read_q, mem_write_q, issue_q, illegal_q;

  assign opcode = bus.instr[OPCODE_LSB +: 6];
  assign rs     = bus.instr[RS_LSB +: 5];
  assign rt     = bus.instr[RT_LSB +: 5];
  assign rd     = bus.instr[RD_LSB +: 5];
  assign funct  = bus.instr[FUNCT_LSB +: 6];
  assign imm    = bus.instr[IMM_LSB +: 16];
  assign dec    = decode(opcode, funct);
  assign dest   = dec.dest_write ? (dec.dest_is_rt ? rt : rd) : '0;

  reg_file u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .we_i      (bus.wbEnable),
    .waddr_i   (bus.wbAddr),
    .wdata_i   (bus.wbData),
    .raddr_a_i (rs),
    .rdata_a_o (rs_val),
    .raddr_b_i (rt),
    .rdata_b_o (rt_val)
  );

  // Hazard check against the pending mask with this cycle's writeback retired
  always_comb begin
    wb_clear = '0;
    if (bus.wbEnable) wb_clear[bus.wbAddr] = 1'b1;
    pending_eff = pending_q & ~wb_clear;
    hazard      = pending_eff[rs] | (dec.reads_rt & pending_eff[rt]);
  end

  assign bus.instrReady = ~rst & ~hazard;
  assign accept         = bus.instrValid & bus.instrReady;
  assign issue          = accept & dec.legal;

  // Scoreboard next state: a new issue overrides a same-cycle clear
  always_comb begin
    pending_d = pending_eff;
    if (issue && dec.dest_write) pending_d[dest] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Scoreboard and issue registers; data outputs hold when nothing issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      ctrl_q       <= ALU_AND;
      a_q          <= '0;
      b_q          <= '0;
      store_q      <= '0;
      dest_q       <= '0;
      dest_write_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      issue_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      issue_q   <= issue;
      illegal_q <= accept & ~dec.legal;
      if (issue) begin
        ctrl_q       <= dec.ctrl;
        a_q          <= rs_val;
        b_q          <= dec.use_imm ? sext16(imm) : rt_val;
        store_q      <= rt_val;
        dest_q       <= dest;
        dest_write_q <= dec.dest_write;
        mem_read_q   <= dec.mem_read;
        mem_write_q  <= dec.mem_write;
      end
    end
  end

  assign bus.inputULA   = ctrl_q;
  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.storeData  = store_q;
  assign bus.destReg    = dest_q;
  assign bus.destWrite  = dest_write_q;
  assign bus.memRead    = mem_read_q;
  assign bus.memWrite   = mem_write_q;
  assign bus.issueValid = issue_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_ula_decode_stage.sv
// Bench for ula_decode_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_ula_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ula_decode_stage_if bus ();

  ula_decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          e_issue, e_ill, e_dw, e_mr, e_mw;
  logic [3:0]  e_ctrl;
  logic [31:0] e_a, e_b, e_sd;
  logic [4:0]  e_dest;

  function automatic logic [31:0] mval(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (bus.wbEnable && bus.wbAddr == r) return bus.wbData;
    return m_regs[r];
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return m_pend[r] && !(bus.wbEnable && bus.wbAddr == r);
  endfunction

  // Meaning of one instruction word, straight from the decode table
  function automatic void m_decode(input logic [31:0] ins, output bit legal,
                                   output logic [3:0] ctrl, output bit imm_b,
                                   output bit uses_rt, output bit dw,
                                   output logic [4:0] dst, output bit mr, output bit mw);
    logic [5:0] op, fn;
    op = ins[31:26]; fn = ins[5:0];
    legal = 1; ctrl = 4'b0010; imm_b = 1; uses_rt = 0; dw = 1;
    dst = ins[20:16]; mr = 0; mw = 0;
    if (op == 6'h00) begin
      imm_b = 0; uses_rt = 1; dst = ins[15:11];
      if      (fn == 6'h20) ctrl = 4'b0010;
      else if (fn == 6'h22) ctrl = 4'b0110;
      else if (fn == 6'h24) ctrl = 4'b0000;
      else if (fn == 6'h25) ctrl = 4'b0001;
      else if (fn == 6'h2A) ctrl = 4'b0111;
      else legal = 0;
    end else if (op == 6'h08) begin
    end else if (op == 6'h0A) ctrl = 4'b0111;
    else if (op == 6'h23) mr = 1;
    else if (op == 6'h2B) begin dw = 0; uses_rt = 1; mw = 1; end
    else if (op == 6'h04) begin ctrl = 4'b0110; imm_b = 0; dw = 0; uses_rt = 1; end
    else legal = 0;
  endfunction

  function automatic bit m_ready();
    bit lg, ib, ur, dw, mr, mw;
    logic [3:0] c;
    logic [4:0] d;
    if (rst) return 0;
    m_decode(bus.instr, lg, c, ib, ur, dw, d, mr, mw);
    return !(busy(bus.instr[25:21]) || (ur && busy(bus.instr[20:16])));
  endfunction

  bit          mi_lg, mi_ib, mi_ur, mi_dw, mi_mr, mi_mw, mi_acc;
  logic [3:0]  mi_c;
  logic [4:0]  mi_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
      e_issue = 0; e_ill = 0; e_dw = 0; e_mr = 0; e_mw = 0;
      e_ctrl = 0; e_a = 0; e_b = 0; e_sd = 0; e_dest = 0;
    end else begin
      m_decode(bus.instr, mi_lg, mi_c, mi_ib, mi_ur, mi_dw, mi_d, mi_mr, mi_mw);
      mi_acc  = bus.instrValid && m_ready();
      e_issue = mi_acc && mi_lg;
      e_ill   = mi_acc && !mi_lg;
      if (e_issue) begin
        e_ctrl = mi_c;
        e_a    = mval(bus.instr[25:21]);
        e_b    = mi_ib ? {{16{bus.instr[15]}}, bus.instr[15:0]} : mval(bus.instr[20:16]);
        e_sd   = mval(bus.instr[20:16]);
        e_dw   = mi_dw; e_mr = mi_mr; e_mw = mi_mw;
        e_dest = mi_dw ? mi_d : 5'd0;
      end
      if (bus.wbEnable && bus.wbAddr != 0) begin
        m_regs[bus.wbAddr] = bus.wbData;
        m_pend[bus.wbAddr] = 0;
      end
      if (e_issue && mi_dw && mi_d != 0) m_pend[mi_d] = 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("instrReady", 32'(bus.instrReady), 32'(m_ready()));
    check("issueValid", 32'(bus.issueValid), 32'(e_issue));
    check("illegal",    32'(bus.illegal),    32'(e_ill));
    check("inputULA",   32'(bus.inputULA),   32'(e_ctrl));
    check("a",          bus.a,               e_a);
    check("b",          bus.b,               e_b);
    check("storeData",  bus.storeData,       e_sd);
    check("destWrite",  32'(bus.destWrite),  32'(e_dw));
    check("memRead",    32'(bus.memRead),    32'(e_mr));
    check("memWrite",   32'(bus.memWrite),   32'(e_mw));
    if (e_dw) check("destReg", 32'(bus.destReg), 32'(e_dest));
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fns [5];
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int k;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    k   = $urandom_range(0, 11);
    case (k)
      0, 1, 2, 3, 4: return enc_r(rs, rt, rd, fns[k]);
      5:  return enc_i(6'h08, rs, rt, imm);
      6:  return enc_i(6'h0A, rs, rt, imm);
      7:  return enc_i(6'h23, rs, rt, imm);
      8:  return enc_i(6'h2B, rs, rt, imm);
      9:  return enc_i(6'h04, rs, rt, imm);
      10: return enc_r(rs, rt, rd, 6'h27);
      default: return enc_i(6'h3F, rs, rt, imm);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wb(input bit en, input logic [4:0] adr, input logic [31:0] dat);
    bus.wbEnable = en; bus.wbAddr = adr; bus.wbData = dat;
  endtask

  task automatic put(input bit v, input logic [31:0] ins);
    bus.instrValid = v; bus.instr = ins;
  endtask

  initial begin
    rst = 1'b1;
    put(0, 32'd0);
    wb(0, 5'd0, 32'd0);
    tick(); tick();
    check("rst_ready", 32'(bus.instrReady), 32'd0);
    check("rst_issue", 32'(bus.issueValid), 32'd0);
    check("rst_a",     bus.a,               32'd0);
    rst = 1'b0;

    // Writebacks r1=5, r2=3, then add r3,r1,r2
    wb(1, 5'd1, 32'd5); tick();
    wb(1, 5'd2, 32'd3); tick();
    wb(0, 5'd0, 32'd0); put(1, enc_r(5'd1, 5'd2, 5'd3, 6'h20)); tick();
    check("add_ctrl",  32'(bus.inputULA),   32'h2);
    check("add_a",     bus.a,               32'd5);
    check("add_b",     bus.b,               32'd3);
    check("add_dest",  32'(bus.destReg),    32'd3);
    check("add_issue", 32'(bus.issueValid), 32'd1);

    // addi r4,r0,-2 then slti r8,r1,7
    put(1, enc_i(6'h08, 5'd0, 5'd4, 16'hFFFE)); tick();
    check("addi_b",    bus.b,             32'hFFFF_FFFE);
    check("addi_a",    bus.a,             32'd0);
    check("addi_ctrl", 32'(bus.inputULA), 32'h2);
    put(1, enc_i(6'h0A, 5'd1, 5'd8, 16'd7)); tick();
    check("slti_ctrl", 32'(bus.inputULA), 32'h7);

    // RAW stall: sub r5,r1,r2 then and r6,r5,r1
    put(1, enc_r(5'd1, 5'd2, 5'd5, 6'h22)); tick();
    put(1, enc_r(5'd5, 5'd1, 5'd6, 6'h24)); #1;
    check("raw_stall_ready", 32'(bus.instrReady), 32'd0);
    tick();
    check("raw_stall_issue", 32'(bus.issueValid), 32'd0);
    wb(1, 5'd5, 32'd2); #1;
    check("raw_wb_ready", 32'(bus.instrReady), 32'd1);
    tick();
    wb(0, 5'd0, 32'd0); put(0, 32'd0);
    check("raw_bypass_a", bus.a,               32'd2);
    check("raw_issue",    32'(bus.issueValid), 32'd1);
    check("raw_ctrl",     32'(bus.inputULA),   32'h0);

    // Register 0: writes ignored, never pending
    wb(1, 5'd0, 32'd99); put(1, enc_i(6'h08, 5'd1, 5'd0, 16'd1)); tick();
    wb(0, 5'd0, 32'd0); put(1, enc_r(5'd0, 5'd0, 5'd9, 6'h20)); #1;
    check("r0_ready", 32'(bus.instrReady), 32'd1);
    tick();
    check("r0_a", bus.a, 32'd0);
    check("r0_b", bus.b, 32'd0);

    // Same-cycle set and clear of r7 leaves it pending
    put(1, enc_i(6'h08, 5'd0, 5'd7, 16'd1)); tick();
    put(1, enc_i(6'h08, 5'd0, 5'd7, 16'd2)); wb(1, 5'd7, 32'd33); tick();
    wb(0, 5'd0, 32'd0); put(1, enc_r(5'd7, 5'd0, 5'd11, 6'h20)); #1;
    check("r7_pending", 32'(bus.instrReady), 32'd0);
    wb(1, 5'd7, 32'd44); #1;
    check("r7_cleared", 32'(bus.instrReady), 32'd1);
    tick();
    wb(0, 5'd0, 32'd0);
    check("r7_a", bus.a, 32'd44);

    // Unsupported funct 0x27
    put(1, enc_r(5'd1, 5'd2, 5'd12, 6'h27)); tick();
    check("ill_pulse", 32'(bus.illegal),    32'd1);
    check("ill_issue", 32'(bus.issueValid), 32'd0);
    check("ill_hold",  bus.a,               32'd44);
    put(1, enc_r(5'd12, 5'd0, 5'd13, 6'h20)); #1;
    check("ill_no_pend", 32'(bus.instrReady), 32'd1);
    tick();
    check("ill_done", 32'(bus.illegal), 32'd0);

    // lw r14,8(r1) and sw r2,-4(r1)
    put(1, enc_i(6'h23, 5'd1, 5'd14, 16'd8)); tick();
    check("lw_mr",   32'(bus.memRead), 32'd1);
    check("lw_b",    bus.b,            32'd8);
    check("lw_dest", 32'(bus.destReg), 32'd14);
    put(1, enc_i(6'h2B, 5'd1, 5'd2, 16'hFFFC)); tick();
    check("sw_mw", 32'(bus.memWrite),  32'd1);
    check("sw_sd", bus.storeData,      32'd3);
    check("sw_b",  bus.b,              32'hFFFF_FFFC);
    check("sw_dw", 32'(bus.destWrite), 32'd0);

    // Reset in the middle of a stall
    put(1, enc_r(5'd1, 5'd2, 5'd15, 6'h22)); tick();
    put(1, enc_r(5'd15, 5'd1, 5'd16, 6'h24)); #1;
    check("mid_stall", 32'(bus.instrReady), 32'd0);
    wb(1, 5'd1, 32'd77); rst = 1'b1; #1;
    check("mid_rst_issue", 32'(bus.issueValid), 32'd0);
    check("mid_rst_ctrl",  32'(bus.inputULA),   32'd0);
    check("mid_rst_sd",    bus.storeData,       32'd0);
    check("mid_rst_ready", 32'(bus.instrReady), 32'd0);
    tick();
    rst = 1'b0; wb(0, 5'd0, 32'd0); #1;
    check("post_rst_ready", 32'(bus.instrReady), 32'd1);
    tick();
    check("post_rst_a", bus.a, 32'd0);
    check("post_rst_b", bus.b, 32'd0);

    // Randomized traffic, occasionally interrupted by reset
    for (int n = 0; n < 600; n++) begin
      put($urandom_range(0, 3) != 0, rand_instr());
      wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) rst = 1'b1;
      tick();
    end
    put(0, 32'd0); wb(0, 5'd0, 32'd0); rst = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
